aim_ternary_neuron_stream: RTL

//  Parametrised, streaming successor to the fixed 20-input ternary AIM neuron.

---
 rtl/aim_pkg.sv | 26 ++
 rtl/aim_ternary_neuron_stream_if.sv | 28 ++
 rtl/aim_ternary_lane_sum.sv | 29 ++
 rtl/aim_ternary_neuron_stream.sv | 114 +++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// Shared constants and helpers for the streaming ternary neuron: weight codes,
// FSM state encoding and a generic signed saturation function.
package aim_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_RSVD = 2'b10;
  localparam logic [1:0] W_NEG  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Clamp v into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned       w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/aim_ternary_neuron_stream_if.sv
// Input beat stream, per-neuron controls and result stream of the ternary neuron.
interface aim_ternary_neuron_stream_if #(
  parameter int ACT_W = 9,
  parameter int LANES = 4,
  parameter int OUT_W = 13
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*ACT_W-1:0]   in_act;
  logic [LANES*2-1:0]       in_wgt;
  logic signed [OUT_W-1:0]  bias;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     wgt_err;

  modport master (
    output in_valid, in_act, in_wgt, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat, wgt_err
  );

  modport slave (
    input  in_valid, in_act, in_wgt, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat, wgt_err
  );
endinterface

// File: rtl/aim_ternary_lane_sum.sv
// Combinational sum of LANES ternary-weighted activations for one beat,
// plus a flag raised when any lane carries the reserved weight code.
module aim_ternary_lane_sum
  import aim_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACT_W = 9,
  parameter int ACC_W = 15
) (
  input  logic [LANES*ACT_W-1:0]  i_act,
  input  logic [LANES*2-1:0]      i_wgt,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_rsvd
);

  always_comb begin
    o_sum  = '0;
    o_rsvd = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      case (i_wgt[l*2 +: 2])
        W_POS:   o_sum = o_sum + ACC_W'(signed'(i_act[l*ACT_W +: ACT_W]));
        W_NEG:   o_sum = o_sum - ACC_W'(signed'(i_act[l*ACT_W +: ACT_W]));
        W_RSVD:  o_rsvd = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aim_ternary_neuron_stream.sv
// Streaming ternary neuron: accumulates BEATS beats of LANES products, adds bias,
// optional ReLU, saturates to OUT_W and holds the result until downstream accepts it.
module aim_ternary_neuron_stream
  import aim_pkg::*;
#(
  parameter int ACT_W = 9,
  parameter int N_IN  = 20,
  parameter int LANES = 4,
  parameter int OUT_W = 13
) (
  input logic                      clk,
  input logic                      rst,
  aim_ternary_neuron_stream_if.slave s
);

  localparam int BEATS = N_IN / LANES;
  localparam int ACC_W = ACT_W + $clog2(N_IN) + 1;
  localparam int CNT_W = $clog2(BEATS + 1);

  generate
    if (N_IN % LANES != 0) begin : g_bad_lanes
      $error("N_IN must be a multiple of LANES");
    end
  endgenerate

  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [OUT_W-1:0]  r_bias;
  logic                     r_relu;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;
  logic                     r_wgt_err;

  logic signed [ACC_W-1:0]  w_partial;
  logic                     w_rsvd;
  logic                     w_xfer;
  logic                     w_first;
  logic                     w_last;
  logic [CNT_W-1:0]         w_cnt_next;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [OUT_W-1:0]  w_bias_sel;
  logic                     w_relu_sel;
  logic signed [31:0]       w_sum;
  logic signed [31:0]       w_relu_out;
  logic signed [31:0]       w_sat_val;
  logic                     w_clip;

  aim_ternary_lane_sum #(
    .LANES (LANES),
    .ACT_W (ACT_W),
    .ACC_W (ACC_W)
  ) u_lane_sum (
    .i_act  (s.in_act),
    .i_wgt  (s.in_wgt),
    .o_sum  (w_partial),
    .o_rsvd (w_rsvd)
  );

  // While holding a result, a new first beat is only taken alongside the output handshake.
  assign s.in_ready  = (r_state == S_HOLD) ? s.out_ready : 1'b1;
  assign s.out_valid = (r_state == S_HOLD);
  assign s.out_data  = r_out_data;
  assign s.out_sat   = r_out_sat;
  assign s.wgt_err   = r_wgt_err;

  assign w_xfer     = s.in_valid && s.in_ready;
  assign w_first    = (r_state != S_ACC);
  assign w_cnt_next = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_last     = (w_cnt_next == CNT_W'(BEATS));
  assign w_acc_next = w_first ? w_partial : r_acc + w_partial;
  assign w_bias_sel = w_first ? s.bias : r_bias;
  assign w_relu_sel = w_first ? s.relu_en : r_relu;

  // Result path sees the final accumulator value in the same cycle as the last beat.
  assign w_sum      = 32'(w_acc_next) + 32'(w_bias_sel);
  assign w_relu_out = (w_relu_sel && (w_sum < 0)) ? 32'sd0 : w_sum;
  assign w_sat_val  = saturate(w_relu_out, OUT_W);
  assign w_clip     = (w_sat_val != w_relu_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_bias     <= '0;
      r_relu     <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_wgt_err  <= 1'b0;
    end else begin
      if (w_xfer && w_rsvd) r_wgt_err <= 1'b1;
      if (w_xfer) begin
        r_acc <= w_acc_next;
        if (w_first) begin
          r_bias <= s.bias;
          r_relu <= s.relu_en;
        end
        if (w_last) begin
          r_out_data <= w_sat_val[OUT_W-1:0];
          r_out_sat  <= w_clip;
          r_cnt      <= '0;
          r_state    <= S_HOLD;
        end else begin
          r_cnt   <= w_cnt_next;
          r_state <= S_ACC;
        end
      end else if ((r_state == S_HOLD) && s.out_ready) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
